// File: rtl/weight_sram_loader.sv
// Weight SRAM loader: packs IN_W-bit valid/ready beats into SRAM_W-bit words
// and writes them into the weight SRAM starting at a programmable base address.
//
// Ports:
//   clk, rst_n (sync, active low)
//   start/base_addr/num_words : transfer request, sampled while idle
//   in_valid/in_ready/in_data : input beat stream (beat k -> bits [k*IN_W +: IN_W])
//   in_last                   : only with WLOAD_LAST_PAD_EN; ends transfer early
//   sram_csb/wsb/waddr/wdata  : registered SRAM write port (active-low enables)
//   busy/done/err             : status to the top controller
//
// Build option: define WLOAD_LAST_PAD_EN to add in_last and zero-pad the
// partial final word.
module weight_sram_loader #(
    parameter int IN_W   = 64,
    parameter int SRAM_W = 512,
    parameter int DEPTH  = 1728,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
`ifdef WLOAD_LAST_PAD_EN
    input  logic              in_last,
`endif
    output logic              sram_csb,
    output logic              sram_wsb,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [SRAM_W-1:0] sram_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BEATS = SRAM_W / IN_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH - 1);
    localparam logic [BW-1:0]     LAST_B   = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   num_q, num_d;
    logic [SRAM_W-1:0]   buf_q, buf_d;
    logic                last_q, last_d;
    logic                err_q, err_d;
    logic                csb_q, csb_d;
    logic                wsb_q, wsb_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [SRAM_W-1:0]   wdata_q, wdata_d;

    logic [SRAM_W-1:0]   word_nxt;
    logic                last_in;
    logic                bad_req;
    logic [ADDR_W:0]     cnt_inc;

`ifdef WLOAD_LAST_PAD_EN
    assign last_in = in_last;
`else
    assign last_in = 1'b0;
`endif

    assign bad_req = (base_addr > LAST_A) || ({1'b0, num_words} > DEPTH_X);
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    always_comb begin
        // Buffer is cleared after each word, so beats not yet written stay
        // zero; this provides the zero-fill for an early-terminated word.
        word_nxt = buf_q;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BW'(k)) begin
                word_nxt[k*IN_W +: IN_W] = in_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        num_d   = num_q;
        buf_d   = buf_q;
        last_d  = last_q;
        err_d   = err_q;
        csb_d   = 1'b1;
        wsb_d   = 1'b1;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (bad_req) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = base_addr;
                        num_d   = num_words;
                        cnt_d   = '0;
                        beat_d  = '0;
                        buf_d   = '0;
                        last_d  = 1'b0;
                        state_d = (num_words == '0) ? S_DONE : S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    buf_d  = word_nxt;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_B || last_in) begin
                        // Word complete: register the SRAM write so the
                        // strobes are asserted for exactly the WRITE cycle.
                        state_d = S_WRITE;
                        csb_d   = 1'b0;
                        wsb_d   = 1'b0;
                        waddr_d = addr_q;
                        wdata_d = word_nxt;
                        buf_d   = '0;
                        beat_d  = '0;
                        last_d  = last_in;
                    end
                end
            end
            S_WRITE: begin
                cnt_d  = cnt_inc[ADDR_W-1:0];
                addr_d = (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
                if (last_q || cnt_inc >= {1'b0, num_q}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            num_q   <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            csb_q   <= 1'b1;
            wsb_q   <= 1'b1;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
            err_q   <= err_d;
            csb_q   <= csb_d;
            wsb_q   <= wsb_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = (state_q == S_FILL);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign sram_csb   = csb_q;
    assign sram_wsb   = wsb_q;
    assign sram_waddr = waddr_q;
    assign sram_wdata = wdata_q;

endmodule
